// File: rtl/cpu_mon_pkg.sv
// rtl/cpu_mon_pkg.sv - shared types and defaults for the run controller / trace monitor
package cpu_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } run_state_e;

    typedef enum logic [1:0] {
        STAT_NONE    = 2'd0,
        STAT_HALT    = 2'd1,
        STAT_TIMEOUT = 2'd2,
        STAT_HANG    = 2'd3
    } run_status_e;

    localparam logic [31:0] HALT_PC_DEFAULT = 32'hF000_0000;

endpackage

// File: rtl/trace_ring.sv
// rtl/trace_ring.sv - ring buffer of fetched PC/instruction pairs with a newest-first registered read port
module trace_ring #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int TW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            wr_en_i,
    input  logic [XLEN-1:0] wr_pc_i,
    input  logic [31:0]     wr_instr_i,
    input  logic [TW-1:0]   rd_idx_i,
    output logic [XLEN-1:0] rd_pc_o,
    output logic [31:0]     rd_instr_o,
    output logic [TW:0]     count_o
);

    logic [XLEN+31:0] mem [DEPTH];
    logic [TW-1:0]    wr_ptr_q;
    logic [TW:0]      count_q;
    logic [TW-1:0]    rd_addr;
    logic [XLEN-1:0]  rd_pc_q;
    logic [31:0]      rd_instr_q;

    // Storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_ptr_q] <= {wr_pc_i, wr_instr_i};
        end
    end

    // Address arithmetic wraps naturally at TW bits; reads see the pre-write view.
    assign rd_addr = wr_ptr_q - TW'(1) - rd_idx_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rd_pc_q    <= '0;
            rd_instr_q <= '0;
        end else begin
            {rd_pc_q, rd_instr_q} <= mem[rd_addr];
            if (clr_i) begin
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else if (wr_en_i) begin
                wr_ptr_q <= wr_ptr_q + TW'(1);
                if (count_q != (TW+1)'(DEPTH)) begin
                    count_q <= count_q + (TW+1)'(1);
                end
            end
        end
    end

    assign rd_pc_o    = rd_pc_q;
    assign rd_instr_o = rd_instr_q;
    assign count_o    = count_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - core reset sequencer, run-cycle counter and end-of-run detector
module cpu_run_monitor
    import cpu_mon_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] HALT_PC     = XLEN'(HALT_PC_DEFAULT),
    parameter int              MAX_CYCLES  = 1000,
    parameter int              STALL_LIMIT = 64,
    parameter int              RST_CYCLES  = 2,
    parameter int              TRACE_DEPTH = 16,
    parameter int              TW          = $clog2(TRACE_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     instr,
    input  logic            pc_valid,
    output logic            cpu_rstn,
    output logic            running,
    output logic            done,
    output logic [1:0]      status,
    output logic [31:0]     cycle_count,
    output logic [TW:0]     trace_count,
    input  logic [TW-1:0]   trace_rd_idx,
    output logic [XLEN-1:0] trace_rd_pc,
    output logic [31:0]     trace_rd_instr
);

    localparam int RCW = $clog2(RST_CYCLES + 1);

    run_state_e      state_q, state_d;
    run_status_e     status_q, status_d;
    logic [RCW-1:0]  rcnt_q, rcnt_d;
    logic [31:0]     cycle_q, cycle_d, cycle_inc;
    logic [31:0]     stall_q, stall_d;
    logic [XLEN-1:0] last_pc_q, last_pc_d;
    logic            last_vld_q, last_vld_d;
    logic            cpu_rstn_q, running_q, done_q;
    logic            trace_clr, trace_wr;
    logic            pc_repeat, end_halt, end_timeout, end_hang;

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        rcnt_d     = rcnt_q;
        cycle_d    = cycle_q;
        stall_d    = stall_q;
        last_pc_d  = last_pc_q;
        last_vld_d = last_vld_q;
        trace_clr  = 1'b0;
        trace_wr   = 1'b0;

        cycle_inc   = cycle_q + 32'd1;
        // The first valid PC of a run has nothing to repeat, whatever its value.
        pc_repeat   = pc_valid && last_vld_q && (pc == last_pc_q);
        end_halt    = pc_valid && (pc == HALT_PC);
        end_timeout = (cycle_inc == 32'(MAX_CYCLES));
        end_hang    = pc_repeat && ((stall_q + 32'd1) == 32'(STALL_LIMIT));

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RESET;
                    status_d   = STAT_NONE;
                    rcnt_d     = '0;
                    cycle_d    = '0;
                    stall_d    = '0;
                    last_vld_d = 1'b0;
                    trace_clr  = 1'b1;
                end
            end
            ST_RESET: begin
                if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    rcnt_d = rcnt_q + RCW'(1);
                end
            end
            ST_RUN: begin
                cycle_d  = cycle_inc;
                trace_wr = pc_valid;
                if (pc_repeat) begin
                    stall_d = stall_q + 32'd1;
                end else if (pc_valid) begin
                    stall_d    = '0;
                    last_pc_d  = pc;
                    last_vld_d = 1'b1;
                end
                if (end_halt) begin
                    status_d = STAT_HALT;
                    state_d  = ST_DONE;
                end else if (end_timeout) begin
                    status_d = STAT_TIMEOUT;
                    state_d  = ST_DONE;
                end else if (end_hang) begin
                    status_d = STAT_HANG;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            status_q   <= STAT_NONE;
            rcnt_q     <= '0;
            cycle_q    <= '0;
            stall_q    <= '0;
            last_pc_q  <= '0;
            last_vld_q <= 1'b0;
            cpu_rstn_q <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            rcnt_q     <= rcnt_d;
            cycle_q    <= cycle_d;
            stall_q    <= stall_d;
            last_pc_q  <= last_pc_d;
            last_vld_q <= last_vld_d;
            cpu_rstn_q <= (state_d == ST_RUN);
            running_q  <= (state_d == ST_RUN);
            done_q     <= (state_d == ST_DONE);
        end
    end

    trace_ring #(
        .XLEN  (XLEN),
        .DEPTH (TRACE_DEPTH),
        .TW    (TW)
    ) u_trace (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (trace_clr),
        .wr_en_i    (trace_wr),
        .wr_pc_i    (pc),
        .wr_instr_i (instr),
        .rd_idx_i   (trace_rd_idx),
        .rd_pc_o    (trace_rd_pc),
        .rd_instr_o (trace_rd_instr),
        .count_o    (trace_count)
    );

    assign cpu_rstn    = cpu_rstn_q;
    assign running     = running_q;
    assign done        = done_q;
    assign status      = status_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb/tb_cpu_run_monitor.sv - randomized, model-checked bench for cpu_run_monitor
module tb_cpu_run_monitor;

    localparam int          XLEN  = 32;
    localparam int          MAXC  = 20;
    localparam int          STALL = 8;
    localparam int          RSTC  = 2;
    localparam int          DEPTH = 8;
    localparam int          TW    = 3;
    localparam logic [31:0] HALT  = 32'hF000_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [XLEN-1:0] pc = '0;
    logic [31:0]     instr = '0;
    logic            pc_valid = 1'b0;
    logic [TW-1:0]   trace_rd_idx = '0;
    logic            cpu_rstn, running, done;
    logic [1:0]      status;
    logic [31:0]     cycle_count;
    logic [TW:0]     trace_count;
    logic [XLEN-1:0] trace_rd_pc;
    logic [31:0]     trace_rd_instr;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    cpu_run_monitor #(
        .XLEN        (XLEN),
        .HALT_PC     (HALT),
        .MAX_CYCLES  (MAXC),
        .STALL_LIMIT (STALL),
        .RST_CYCLES  (RSTC),
        .TRACE_DEPTH (DEPTH),
        .TW          (TW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .pc             (pc),
        .instr          (instr),
        .pc_valid       (pc_valid),
        .cpu_rstn       (cpu_rstn),
        .running        (running),
        .done           (done),
        .status         (status),
        .cycle_count    (cycle_count),
        .trace_count    (trace_count),
        .trace_rd_idx   (trace_rd_idx),
        .trace_rd_pc    (trace_rd_pc),
        .trace_rd_instr (trace_rd_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 core-reset, 2 run, 3 done; trace kept newest-first.
    int          m_phase, m_rst_left, m_cycles, m_status, m_stall;
    logic [63:0] m_q[$];
    logic [31:0] m_last;
    bit          m_have_last, m_rd_valid;
    logic [63:0] m_rd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_rst_left = 0; m_cycles = 0; m_status = 0; m_stall = 0;
            m_q.delete(); m_have_last = 0; m_rd_valid = 0; m_rd = '0; m_last = '0;
        end else begin
            if (int'(trace_rd_idx) < m_q.size()) begin
                m_rd_valid = 1; m_rd = m_q[trace_rd_idx];
            end else begin
                m_rd_valid = 0;
            end
            case (m_phase)
                0, 3: if (start) begin
                    m_phase = 1; m_rst_left = RSTC; m_cycles = 0; m_status = 0;
                    m_stall = 0; m_have_last = 0; m_q.delete();
                end
                1: begin
                    m_rst_left--;
                    if (m_rst_left == 0) m_phase = 2;
                end
                default: begin
                    m_cycles++;
                    if (pc_valid) begin
                        m_q.push_front({pc, instr});
                        if (m_q.size() > DEPTH) void'(m_q.pop_back());
                        if (m_have_last && pc == m_last) m_stall++;
                        else begin m_stall = 0; m_last = pc; m_have_last = 1; end
                    end
                    if (pc_valid && pc == HALT) m_status = 1;
                    else if (m_cycles == MAXC) m_status = 2;
                    else if (pc_valid && m_stall == STALL) m_status = 3;
                    if (m_status != 0) m_phase = 3;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en && !rst) begin
            chk("running", 64'(running), 64'(m_phase == 2));
            chk("done", 64'(done), 64'(m_phase == 3));
            chk("cpu_rstn", 64'(cpu_rstn), 64'(m_phase == 2));
            chk("status", 64'(status), 64'(m_status));
            chk("cycle_count", 64'(cycle_count), 64'(m_cycles));
            chk("trace_count", 64'(trace_count), 64'(m_q.size()));
            if (m_rd_valid) begin
                chk("rd_pc", 64'(trace_rd_pc), 64'(m_rd[63:32]));
                chk("rd_instr", 64'(trace_rd_instr), 64'(m_rd[31:0]));
            end
        end
    end

    task automatic drive(input logic [31:0] p, input logic v);
        pc = p; pc_valid = v; instr = $urandom;
        @(negedge clk);
    endtask

    task automatic begin_run();
        int n;
        start = 1'b1; pc_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("restart_cycles", 64'(cycle_count), 64'd0);
        chk("restart_status", 64'(status), 64'd0);
        n = 0;
        while (!running && n < 10) begin @(negedge clk); n++; end
        chk("wait_running", 64'(running), 64'd1);
    endtask

    task automatic run_until_done(input logic [31:0] p0, input logic [31:0] step, input logic v);
        int n;
        logic [31:0] p;
        p = p0; n = 0;
        while (!done && n < 40) begin drive(p, v); p += step; n++; end
        pc_valid = 1'b0;
        chk("reached_done", 64'(done), 64'd1);
    endtask

    task automatic read_trace(input int idx, input string nm, input logic [31:0] exp);
        trace_rd_idx = TW'(idx);
        @(negedge clk);
        chk(nm, 64'(trace_rd_pc), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode;
        logic [31:0] cur;
        repeat (3) @(negedge clk);
        chk("rst_cpu_rstn", 64'(cpu_rstn), 64'd0);
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_cycles", 64'(cycle_count), 64'd0);
        chk("rst_tcount", 64'(trace_count), 64'd0);
        chk("rst_rd_pc", 64'(trace_rd_pc), 64'd0);
        chk("rst_rd_instr", 64'(trace_rd_instr), 64'd0);
        rst = 1'b0;
        check_en = 1'b1;

        start = 1'b1; @(negedge clk); start = 1'b0;
        chk("rel_rstn_c1", 64'(cpu_rstn), 64'd0);
        @(negedge clk);
        chk("rel_rstn_c2", 64'(cpu_rstn), 64'd0);
        @(negedge clk);
        chk("rel_rstn_run", 64'(cpu_rstn), 64'd1);
        chk("rel_running", 64'(running), 64'd1);

        drive(32'h0, 1); drive(32'h4, 1); drive(32'h8, 1); drive(32'hC, 1); drive(HALT, 1);
        pc_valid = 1'b0;
        chk("halt_done", 64'(done), 64'd1);
        chk("halt_status", 64'(status), 64'd1);
        chk("halt_cycles", 64'(cycle_count), 64'd5);
        chk("halt_tcount", 64'(trace_count), 64'd5);
        read_trace(0, "halt_idx0", HALT);
        read_trace(4, "halt_idx4", 32'h0);

        begin_run();
        start = 1'b1; drive(32'h0, 1); start = 1'b0;
        run_until_done(32'h4, 32'h4, 1);
        chk("tmo_status", 64'(status), 64'd2);
        chk("tmo_cycles", 64'(cycle_count), 64'd20);

        begin_run();
        repeat (4) drive(32'h10, 1);
        repeat (2) drive(32'h10, 0);
        run_until_done(32'h10, 32'h0, 1);
        chk("hang_status", 64'(status), 64'd3);
        chk("hang_cycles", 64'(cycle_count), 64'd11);

        begin_run();
        for (int i = 0; i < 10; i++) drive(32'(i * 4), 1);
        run_until_done(32'h0, 32'h0, 0);
        chk("wrap_status", 64'(status), 64'd2);
        chk("wrap_tcount", 64'(trace_count), 64'd8);
        read_trace(0, "wrap_idx0", 32'h24);
        read_trace(7, "wrap_idx7", 32'h08);

        begin_run();
        for (int i = 0; i < 19; i++) drive(32'h100 + 32'(i * 4), 1);
        drive(HALT, 1);
        pc_valid = 1'b0;
        chk("prio_status", 64'(status), 64'd1);
        chk("prio_cycles", 64'(cycle_count), 64'd20);

        begin_run();
        drive(32'h200, 1); drive(32'h204, 1);
        rst = 1'b1;
        #1;
        chk("midrst_rstn", 64'(cpu_rstn), 64'd0);
        chk("midrst_running", 64'(running), 64'd0);
        chk("midrst_cycles", 64'(cycle_count), 64'd0);
        chk("midrst_tcount", 64'(trace_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pc_valid = 1'b0;

        for (int r = 0; r < 25; r++) begin
            begin_run();
            mode = $urandom_range(0, 2);
            cur = 32'($urandom_range(0, 15) * 4);
            for (int c = 0; c < 28; c++) begin
                case (mode)
                    0: cur = cur + 32'h4;
                    1: if ($urandom_range(0, 7) == 0) cur = 32'($urandom_range(0, 15) * 4);
                    default: cur = ($urandom_range(0, 9) == 0) ? HALT : 32'($urandom_range(0, 7) * 4);
                endcase
                trace_rd_idx = TW'($urandom_range(0, DEPTH - 1));
                start = running && ($urandom_range(0, 15) == 0);
                drive(cur, $urandom_range(0, 3) != 0);
            end
            start = 1'b0;
            pc_valid = 1'b0;
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
